// File: rtl/temp_mon_pkg.sv
// Shared types, 7-segment codes and conversion helpers for the temperature monitor.
package temp_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } rx_state_e;

  // Segment bit order is {DP,G,F,E,D,C,B,A}, active high
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_DP    = 8'h80;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Largest magnitude the two numeric digits can show
  localparam int DISP_MAX = 99;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 0..99 -> {tens, units} BCD
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Exact integer Fahrenheit; SV signed division truncates toward zero
  function automatic logic signed [31:0] c_to_f(input logic signed [31:0] c);
    return (c * 32'sd9) / 32'sd5 + 32'sd32;
  endfunction

endpackage

// File: rtl/lm70_spi_rx.sv
// LM70-style SPI reader: polls the sensor, shifts a frame MSB-first on SCK
// rising edges and latches the signed integer temperature field.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | cs_n high, poll counter runs for POLL_CYCLES cycles
//   ST_SETUP | cs_n low, sck low for SCK_DIV cycles before the first edge
//   ST_SHIFT | sck toggles every SCK_DIV cycles, data sampled on rise
//   ST_LATCH | cs_n high one cycle, temperature field captured
module lm70_spi_rx
  import temp_mon_pkg::*;
#(
  parameter int FRAME_BITS  = 16,
  parameter int TEMP_W      = 9,
  parameter int SCK_DIV     = 2,
  parameter int POLL_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sio_i,
  output logic                     cs_n_o,
  output logic                     sck_o,
  output logic signed [TEMP_W-1:0] temp_c_o,
  output logic                     valid_o
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(SCK_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(FRAME_BITS);

  // The temperature field is taken from the top of the frame, so it must fit
  if (FRAME_BITS < TEMP_W) begin : g_frame_chk
    $error("lm70_spi_rx: FRAME_BITS must be >= TEMP_W");
  end

  rx_state_e                state_q, state_d;
  logic [PW-1:0]            poll_q, poll_d;
  logic [DW-1:0]            div_q, div_d;
  logic [BW-1:0]            bits_q, bits_d;
  logic                     sck_q, sck_d;
  logic [FRAME_BITS-1:0]    frame_q, frame_d;
  logic signed [TEMP_W-1:0] temp_q;
  logic                     valid_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Timers, SCK phase, shift register and latched result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_q  <= '0;
      div_q   <= '0;
      bits_q  <= '0;
      sck_q   <= 1'b0;
      frame_q <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      poll_q  <= poll_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      sck_q   <= sck_d;
      frame_q <= frame_d;
      valid_q <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) temp_q <= frame_q[FRAME_BITS-1 -: TEMP_W];
    end
  end

  // Next-state and counter logic; sample on the cycle sck goes high
  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    div_d   = div_q;
    bits_d  = bits_q;
    sck_d   = sck_q;
    frame_d = frame_q;
    unique case (state_q)
      ST_IDLE: begin
        if (poll_q == POLL_LAST) begin
          poll_d  = '0;
          div_d   = DIV_LOAD;
          state_d = ST_SETUP;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      ST_SETUP: begin
        if (div_q == '0) begin
          div_d   = DIV_LOAD;
          bits_d  = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_LOAD;
          sck_d = ~sck_q;
          if (!sck_q) begin
            frame_d = {frame_q[FRAME_BITS-2:0], sio_i};
            bits_d  = bits_q + 1'b1;
          end else if (bits_q == BITS_LAST) begin
            state_d = ST_LATCH;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_LATCH: begin
        sck_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Chip select is low only while a frame is being clocked
  always_comb begin
    cs_n_o = 1'b1;
    unique case (state_q)
      ST_SETUP, ST_SHIFT: cs_n_o = 1'b0;
      default:            cs_n_o = 1'b1;
    endcase
  end

  assign sck_o    = sck_q;
  assign temp_c_o = temp_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/temp_monitor_spi_scan.sv
// Temperature monitor top: SPI sensor reader, C/F display conversion with
// saturation, hysteretic over-temperature alarm and 3-digit display scan.
module temp_monitor_spi_scan
  import temp_mon_pkg::*;
#(
  parameter int FRAME_BITS  = 16,
  parameter int TEMP_W      = 9,
  parameter int SCK_DIV     = 2,
  parameter int POLL_CYCLES = 64,
  parameter int DIGIT_HOLD  = 16,
  parameter int ALARM_HI    = 60,
  parameter int ALARM_HYST  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sio_i,
  input  logic                     sel_f_i,
  input  logic                     hold_i,
  output logic                     cs_n_o,
  output logic                     sck_o,
  output logic [7:0]               seg_o,
  output logic [2:0]               digit_en_o,
  output logic signed [TEMP_W-1:0] temp_c_o,
  output logic                     temp_valid_o,
  output logic                     alarm_o,
  output logic                     overflow_o
);

  // Conversion width is wide enough for 9*C with no overflow
  localparam int CW = TEMP_W + 5;
  localparam int HW = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;
  localparam logic [HW-1:0] SCAN_LOAD = HW'(DIGIT_HOLD - 1);
  localparam logic signed [TEMP_W-1:0] ALARM_SET = TEMP_W'(ALARM_HI);
  localparam logic signed [TEMP_W-1:0] ALARM_CLR = TEMP_W'(ALARM_HI - ALARM_HYST);

  logic signed [TEMP_W-1:0] temp_c;
  logic                     temp_valid;

  lm70_spi_rx #(
    .FRAME_BITS (FRAME_BITS),
    .TEMP_W     (TEMP_W),
    .SCK_DIV    (SCK_DIV),
    .POLL_CYCLES(POLL_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .sio_i   (sio_i),
    .cs_n_o  (cs_n_o),
    .sck_o   (sck_o),
    .temp_c_o(temp_c),
    .valid_o (temp_valid)
  );

  logic signed [CW-1:0] temp_ext, temp_f, disp_val;
  logic [CW-1:0]        disp_mag;
  logic                 disp_neg, disp_ovf;
  logic [6:0]           disp_sat;
  logic [7:0]           bcd;
  logic [7:0]           units_seg_d, tens_seg_d, letter_seg_d;

  logic [7:0]    units_seg_q, tens_seg_q, letter_seg_q;
  logic          overflow_q;
  logic          alarm_q;
  logic [HW-1:0] scan_q;
  logic [2:0]    digit_en_q;

  // Display value from the latched temperature: select unit, take magnitude, saturate, encode
  always_comb begin
    temp_ext     = CW'(temp_c);
    temp_f       = CW'(c_to_f(32'(temp_c)));
    disp_val     = sel_f_i ? temp_f : temp_ext;
    disp_neg     = disp_val[CW-1];
    disp_mag     = disp_neg ? -disp_val : disp_val;
    disp_ovf     = (disp_mag > CW'(DISP_MAX));
    disp_sat     = disp_ovf ? 7'(DISP_MAX) : disp_mag[6:0];
    bcd          = bin_to_bcd2(disp_sat);
    units_seg_d  = seg_digit(bcd[3:0]);
    tens_seg_d   = (disp_sat < 7'd10) ? SEG_BLANK : seg_digit(bcd[7:4]);
    letter_seg_d = (sel_f_i ? SEG_F : SEG_C) | (disp_neg ? SEG_DP : SEG_BLANK);
  end

  // Display register: loads once per new reading unless frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units_seg_q  <= SEG_0;
      tens_seg_q   <= SEG_BLANK;
      letter_seg_q <= SEG_C;
      overflow_q   <= 1'b0;
    end else if (temp_valid && !hold_i) begin
      units_seg_q  <= units_seg_d;
      tens_seg_q   <= tens_seg_d;
      letter_seg_q <= letter_seg_d;
      overflow_q   <= disp_ovf;
    end
  end

  // Hysteretic alarm, evaluated on each new reading; the band in between holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (temp_valid) begin
      if (temp_c >= ALARM_SET)     alarm_q <= 1'b1;
      else if (temp_c < ALARM_CLR) alarm_q <= 1'b0;
    end
  end

  // Free-running digit scan, each enable held DIGIT_HOLD cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q     <= SCAN_LOAD;
      digit_en_q <= 3'b001;
    end else if (scan_q == '0) begin
      scan_q     <= SCAN_LOAD;
      digit_en_q <= {digit_en_q[1:0], digit_en_q[2]};
    end else begin
      scan_q <= scan_q - 1'b1;
    end
  end

  // Segment mux follows the active enable in the same cycle
  always_comb begin
    seg_o = units_seg_q;
    if (digit_en_q[1])      seg_o = tens_seg_q;
    else if (digit_en_q[2]) seg_o = letter_seg_q;
  end

  assign digit_en_o   = digit_en_q;
  assign temp_c_o     = temp_c;
  assign temp_valid_o = temp_valid;
  assign alarm_o      = alarm_q;
  assign overflow_o   = overflow_q;

endmodule
